uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// UART transmitter with run-time frame configuration.
// Frame: start bit, DATA_W data bits LSB first, optional parity, one or two stop bits.
// A 1-deep holding register lets a second word queue while a frame is on the line.
// Frame settings are latched with each word, so mid-frame input changes are ignored.
module uart_tx_cfg #(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Data_Valid,
    input  logic [DATA_W-1:0]  P_DATA,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic               STOP2,
    input  logic [PRESC_W-1:0] PRESCALE,
    output logic               TX_OUT,
    output logic               Busy,
    output logic               Ready
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
    localparam logic [PRESC_W-1:0] PRE_ONE  = PRESC_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t              state;
    logic [PRESC_W-1:0]  presc_cnt;
    logic [PRESC_W-1:0]  cur_len;
    logic [IDX_W-1:0]    bit_idx;
    logic                stop_left;
    logic [DATA_W-1:0]   shift_reg;
    logic                cur_par_en;
    logic                cur_par_bit;
    logic                cur_stop2;
    logic [DATA_W-1:0]   hold_data;
    logic                hold_full;

    logic                accept;
    logic                bit_end;
    logic                frame_end;
    logic                hold_move;
    logic                direct_load;
    logic                hold_load;
    logic                start_frame;
    logic [DATA_W-1:0]   load_word;
    logic [PRESC_W-1:0]  new_len;

    // Even parity is the XOR of the data bits; odd parity inverts it.
    function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    // A prescale of zero would give a zero-length bit, so it is promoted to one.
    function automatic logic [PRESC_W-1:0] bit_len(input logic [PRESC_W-1:0] p);
        return (p == '0) ? PRE_ONE : p;
    endfunction

    assign Ready       = ~hold_full;
    assign accept      = Data_Valid & Ready;
    assign bit_end     = (presc_cnt == '0);
    assign frame_end   = (state == STOP) & bit_end & ~stop_left;
    assign hold_move   = frame_end & hold_full;
    // A word goes straight to the shift register when the line is free on this edge.
    assign direct_load = accept & ~hold_full & ((state == IDLE) | frame_end);
    assign hold_load   = accept & ~direct_load;
    assign start_frame = direct_load | hold_move;
    assign load_word   = hold_move ? hold_data : P_DATA;
    assign new_len     = bit_len(PRESCALE);

    // Frame sequencer: holding register, bit timing, and registered line/busy outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            TX_OUT      <= 1'b1;
            Busy        <= 1'b0;
            presc_cnt   <= '0;
            cur_len     <= '0;
            bit_idx     <= '0;
            stop_left   <= 1'b0;
            shift_reg   <= '0;
            cur_par_en  <= 1'b0;
            cur_par_bit <= 1'b0;
            cur_stop2   <= 1'b0;
            hold_data   <= '0;
            hold_full   <= 1'b0;
        end else begin
            if (hold_load) begin
                hold_data <= P_DATA;
                hold_full <= 1'b1;
            end else if (hold_move) begin
                hold_full <= 1'b0;
            end

            if (start_frame) begin
                state       <= START;
                Busy        <= 1'b1;
                TX_OUT      <= 1'b0;
                shift_reg   <= load_word;
                cur_len     <= new_len;
                presc_cnt   <= new_len - PRE_ONE;
                cur_par_en  <= PAR_EN;
                cur_par_bit <= parity_bit(load_word, PAR_TYP);
                cur_stop2   <= STOP2;
                bit_idx     <= '0;
                stop_left   <= 1'b0;
            end else if (state != IDLE) begin
                presc_cnt <= bit_end ? (cur_len - PRE_ONE) : (presc_cnt - PRE_ONE);
                if (bit_end) begin
                    case (state)
                        START: begin
                            state     <= DATA;
                            TX_OUT    <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                            bit_idx   <= '0;
                        end
                        DATA: begin
                            if (bit_idx == LAST_IDX) begin
                                if (cur_par_en) begin
                                    state  <= PARITY;
                                    TX_OUT <= cur_par_bit;
                                end else begin
                                    state     <= STOP;
                                    TX_OUT    <= 1'b1;
                                    stop_left <= cur_stop2;
                                end
                            end else begin
                                bit_idx   <= bit_idx + IDX_ONE;
                                TX_OUT    <= shift_reg[0];
                                shift_reg <= shift_reg >> 1;
                            end
                        end
                        PARITY: begin
                            state     <= STOP;
                            TX_OUT    <= 1'b1;
                            stop_left <= cur_stop2;
                        end
                        STOP: begin
                            if (stop_left) begin
                                stop_left <= 1'b0;
                            end else begin
                                state     <= IDLE;
                                Busy      <= 1'b0;
                                TX_OUT    <= 1'b1;
                                presc_cnt <= '0;
                            end
                        end
                        default: begin
                            state  <= IDLE;
                            Busy   <= 1'b0;
                            TX_OUT <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed testbench for uart_tx_cfg: fixed frames with hand-derived line patterns.
// Expected patterns are strings of '0'/'1' in line order, one character per bit period.
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dv;
    logic [7:0] pdata;
    logic       par_en;
    logic       par_typ;
    logic       stop2;
    logic [5:0] presc;
    logic       tx;
    logic       busy;
    logic       ready;

    logic       dv5;
    logic [4:0] pdata5;
    logic       par_en5;
    logic       par_typ5;
    logic       stop25;
    logic [5:0] presc5;
    logic       tx5;
    logic       busy5;
    logic       ready5;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_cfg #(.DATA_W(8), .PRESC_W(6)) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .Data_Valid (dv),
        .P_DATA     (pdata),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .STOP2      (stop2),
        .PRESCALE   (presc),
        .TX_OUT     (tx),
        .Busy       (busy),
        .Ready      (ready)
    );

    uart_tx_cfg #(.DATA_W(5), .PRESC_W(6)) dut5 (
        .CLK        (clk),
        .RST        (rst_n),
        .Data_Valid (dv5),
        .P_DATA     (pdata5),
        .PAR_EN     (par_en5),
        .PAR_TYP    (par_typ5),
        .STOP2      (stop25),
        .PRESCALE   (presc5),
        .TX_OUT     (tx5),
        .Busy       (busy5),
        .Ready      (ready5)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_bit(input string s, input int k);
        return (s[k] == 8'h31);
    endfunction

    // Send one word on the 8-bit instance and check every cycle of its frame.
    task automatic run_frame(input logic [7:0] d, input string pat, input int len,
                             input bit midchg, input string tag);
        chk({tag, "_ready"}, ready, 1);
        pdata = d;
        dv    = 1'b1;
        tick();
        dv    = 1'b0;
        pdata = ~d;
        for (int i = 0; i < pat.len() * len; i++) begin
            if (midchg && i == 3) begin
                presc  = 6'd5;
                par_en = 1'b0;
            end
            chk({tag, "_tx"}, tx, exp_bit(pat, i / len));
            chk({tag, "_busy"}, busy, 1);
            tick();
        end
        chk({tag, "_idle_tx"}, tx, 1);
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        string p33;
        rst_n = 1'b1;
        dv = 1'b0; pdata = '0; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; presc = 6'd1;
        dv5 = 1'b0; pdata5 = '0; par_en5 = 1'b0; par_typ5 = 1'b0; stop25 = 1'b0; presc5 = 6'd1;

        // Reset state, observed before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 1);
        chk("rst_tx5", tx5, 1);
        tick();
        tick();
        rst_n = 1'b1;

        // Odd parity, 1 cycle/bit; accepted on the first edge after reset release
        presc = 6'd1; par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b0;
        run_frame(8'hCB, "01101001101", 1, 1'b0, "r031");

        // No parity, two stop bits, 4 cycles/bit
        presc = 6'd4; par_en = 1'b0; stop2 = 1'b1;
        run_frame(8'h6A, "00101011011", 4, 1'b0, "r032");

        // Back-to-back words through the holding register; third strobe dropped
        presc = 6'd1; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0;
        p33 = "0101010100101100010101";
        chk("r033_ready0", ready, 1);
        pdata = 8'h55;
        dv    = 1'b1;
        tick();
        dv    = 1'b0;
        for (int i = 0; i < 22; i++) begin
            chk("r033_tx", tx, exp_bit(p33, i));
            chk("r033_busy", busy, 1);
            if (i == 0) begin
                chk("r033_ready_free", ready, 1);
                pdata = 8'hA3;
                dv    = 1'b1;
            end else if (i == 1) begin
                chk("r033_ready_full", ready, 0);
                pdata = 8'hFF;
                dv    = 1'b1;
            end else if (i == 2) begin
                dv = 1'b0;
                chk("r033_ready_still_full", ready, 0);
            end
            if (i == 11) chk("r033_ready_after_move", ready, 1);
            tick();
        end
        chk("r033_idle_tx", tx, 1);
        chk("r033_idle_busy", busy, 0);

        // Mid-frame config change only affects the next frame
        presc = 6'd2; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0;
        run_frame(8'h55, "01010101001", 2, 1'b1, "r036a");
        run_frame(8'h55, "0101010101", 5, 1'b0, "r036b");

        // Reset during data bit 3 with a word held
        presc = 6'd1; par_en = 1'b0; stop2 = 1'b0;
        pdata = 8'h6A;
        dv    = 1'b1;
        tick();
        pdata = 8'h00;
        tick();
        dv    = 1'b0;
        chk("r034_ready_held", ready, 0);
        tick();
        tick();
        tick();
        chk("r034_bit3", tx, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("r034_tx", tx, 1);
        chk("r034_busy", busy, 0);
        chk("r034_ready", ready, 1);
        tick();
        rst_n = 1'b1;
        presc = 6'd1; par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b0;
        run_frame(8'hCB, "01101001101", 1, 1'b0, "r034_next");

        // 5-bit data, prescale 0 behaves as 1, even parity
        chk("r035_ready", ready5, 1);
        presc5 = 6'd0; par_en5 = 1'b1; par_typ5 = 1'b0; stop25 = 1'b0;
        pdata5 = 5'h13;
        dv5    = 1'b1;
        tick();
        dv5    = 1'b0;
        pdata5 = 5'h00;
        for (int i = 0; i < 8; i++) begin
            chk("r035_tx", tx5, exp_bit("01100111", i));
            chk("r035_busy", busy5, 1);
            tick();
        end
        chk("r035_idle_tx", tx5, 1);
        chk("r035_idle_busy", busy5, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
